// File: rtl/qrs_pkg.sv
// Shared widths, the saturating magnitude helper and window-state encoding for the
// QRS feature extractor.
package qrs_pkg;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned MP_W   = 32;
  localparam int unsigned NSCALE = 4;

  typedef enum logic [0:0] {
    WARMUP,
    RUN
  } win_state_t;

  // Magnitude of a two's-complement coefficient; the most negative code clips to max positive.
  function automatic logic [COEF_W-1:0] sat_abs(input logic [COEF_W-1:0] x);
    if (x == {1'b1, {(COEF_W-1){1'b0}}}) begin
      return {1'b0, {(COEF_W-1){1'b1}}};
    end
    if (x[COEF_W-1]) begin
      return ~x + COEF_W'(1);
    end
    return x;
  endfunction

endpackage

// File: rtl/qrs_feature_extractor_abs_peak_tracker.sv
// Per-scale peak tracker: holds the window peak of |d_k| and applies the 3/4 IIR
// threshold update at each window end.
module abs_peak_tracker
  import qrs_pkg::*;
#(
  parameter logic [COEF_W-1:0] VT_INIT = 16'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] a,
  input  logic              s1_valid,
  input  logic              win_end,
  output logic [COEF_W-1:0] vt
);

  logic [COEF_W-1:0] pk_q;
  logic [COEF_W-1:0] vt_q;
  logic [COEF_W-1:0] p;
  logic [COEF_W+1:0] acc;

  // Peak includes the current sample so the window's last value is not lost.
  always_comb begin
    p   = (a > pk_q) ? a : pk_q;
    acc = (COEF_W+2)'(vt_q) * (COEF_W+2)'(3) + (COEF_W+2)'(p);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pk_q <= '0;
      vt_q <= VT_INIT;
    end else if (s1_valid) begin
      if (win_end) begin
        vt_q <= COEF_W'(acc >> 2);
        pk_q <= '0;
      end else begin
        pk_q <= p;
      end
    end
  end

  assign vt = vt_q;

endmodule

// File: rtl/qrs_feature_extractor.sv
// Computes the boxcar-smoothed modulus sum MPavg every sample and the four per-scale
// adaptive thresholds once per analysis window.
module qrs_feature_extractor
  import qrs_pkg::*;
#(
  parameter int unsigned       WIN_LOG2 = 8,
  parameter int unsigned       AVG_LOG2 = 3,
  parameter logic [COEF_W-1:0] VT_INIT  = 16'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [COEF_W-1:0] d1,
  input  logic [COEF_W-1:0] d2,
  input  logic [COEF_W-1:0] d3,
  input  logic [COEF_W-1:0] d4,
  output logic [MP_W-1:0]   MPavg,
  output logic              mp_valid,
  output logic [COEF_W-1:0] Vt1,
  output logic [COEF_W-1:0] Vt2,
  output logic [COEF_W-1:0] Vt3,
  output logic [COEF_W-1:0] Vt4,
  output logic              thr_update,
  output logic              thr_ready
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SW    = COEF_W + 2;
  localparam int unsigned RW    = AVG_LOG2 + SW;

  logic [COEF_W-1:0] d_in [NSCALE];
  logic [COEF_W-1:0] a_q  [NSCALE];
  logic [COEF_W-1:0] vt   [NSCALE];
  logic              s1_valid_q;

  logic [SW-1:0]       hist_q [DEPTH];
  logic [SW-1:0]       s_sum;
  logic [RW-1:0]       r_q;
  logic [RW-1:0]       r_new;
  logic [MP_W-1:0]     mpavg_q;
  logic                mp_valid_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic                win_end;
  logic                thr_update_q;
  win_state_t          state_q;
  win_state_t          state_d;

  assign d_in[0] = d1;
  assign d_in[1] = d2;
  assign d_in[2] = d3;
  assign d_in[3] = d4;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < NSCALE; k++) a_q[k] <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NSCALE; k++) a_q[k] <= sat_abs(d_in[k]);
      end
    end
  end

  // The running sum always contains the oldest entry, so the subtraction cannot underflow.
  always_comb begin
    s_sum = SW'(a_q[0]) + SW'(a_q[1]) + SW'(a_q[2]) + SW'(a_q[3]);
    r_new = r_q + RW'(s_sum) - RW'(hist_q[DEPTH-1]);
  end

  assign win_end = s1_valid_q && (cnt_q == {WIN_LOG2{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      r_q          <= '0;
      mpavg_q      <= '0;
      mp_valid_q   <= 1'b0;
      cnt_q        <= '0;
      thr_update_q <= 1'b0;
    end else begin
      mp_valid_q   <= s1_valid_q;
      thr_update_q <= win_end;
      if (s1_valid_q) begin
        hist_q[0] <= s_sum;
        for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
        r_q     <= r_new;
        mpavg_q <= MP_W'(r_new >> AVG_LOG2);
        cnt_q   <= cnt_q + WIN_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WARMUP;
    else     state_q <= state_d;
  end

  // Transition on the window-end strobe so thr_ready rises together with thr_update.
  always_comb begin
    state_d   = state_q;
    thr_ready = 1'b0;
    unique case (state_q)
      WARMUP: if (win_end) state_d = RUN;
      RUN:    thr_ready = 1'b1;
      default: state_d = WARMUP;
    endcase
  end

  for (genvar k = 0; k < NSCALE; k++) begin : g_trk
    abs_peak_tracker #(
      .VT_INIT (VT_INIT)
    ) u_trk (
      .clk      (clk),
      .rst      (rst),
      .a        (a_q[k]),
      .s1_valid (s1_valid_q),
      .win_end  (win_end),
      .vt       (vt[k])
    );
  end

  assign MPavg      = mpavg_q;
  assign mp_valid   = mp_valid_q;
  assign thr_update = thr_update_q;
  assign Vt1        = vt[0];
  assign Vt2        = vt[1];
  assign Vt3        = vt[2];
  assign Vt4        = vt[3];

endmodule

// File: doc/qrs_feature_extractor.md
Name: qrs_feature_extractor

Overview:
- Upstream stage of the adaptive QRS threshold/decision block.
- Consumes four signed wavelet detail coefficients (scales 2^1..2^4) per ECG sample.
- Produces the smoothed modulus average MPavg every sample, plus the four per-scale thresholds Vt1..Vt4, updated once per analysis window.
- Outputs connect directly to the decision block's Vt1..Vt4 and MPavg inputs.

Parameters:
- WIN_LOG2, 8, log2 of samples per threshold window (256 samples ≈ 1 s at 250 Hz).
- AVG_LOG2, 3, log2 of the boxcar length for MPavg (8 samples).
- VT_INIT, 16'd64, reset and initial value of every Vt threshold.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  d1..d4 carry a new sample this cycle.
- d1, d2, d3, d4  in  16 each  signed two's-complement detail coefficients.
- MPavg  out  32  smoothed sum of coefficient magnitudes.
- mp_valid  out  1  one-cycle pulse: MPavg updated.
- Vt1, Vt2, Vt3, Vt4  out  16 each  per-scale adaptive thresholds.
- thr_update  out  1  one-cycle pulse: Vt1..Vt4 updated.
- thr_ready  out  1  high once the first window has completed.

Behaviour:
- Reset values:
  - MPavg=0, mp_valid=0, thr_update=0, thr_ready=0.
  - Vt1..Vt4=VT_INIT.
  - History registers, running sum, window counter and peak registers all 0.
  - in_valid is ignored while rst is high.
- Stage 1 (cycle t+1 after in_valid at t):
  - a_k = sat_abs(d_k), 16-bit unsigned; sat_abs(-32768)=32767.
  - Register a1..a4 and s1_valid.
- Stage 2 (cycle t+2), MPavg path:
  - S = a1+a2+a3+a4 (18-bit).
  - Push S into a 2^AVG_LOG2-deep shift history.
  - Running sum R <= R + S - oldest (R is AVG_LOG2+18 bits, never overflows).
  - MPavg <= zero-extend(R_new >> AVG_LOG2); mp_valid=1 for that cycle only.
  - Fixed latency: 2 cycles from in_valid to mp_valid.
  - History starts at zero, so the first 2^AVG_LOG2-1 outputs are partial averages; this is defined behaviour.
- Stage 2, threshold path:
  - Per scale: pk_k <= max(pk_k, a_k) on each s1_valid.
  - Window counter cnt (WIN_LOG2 bits) increments on each s1_valid and wraps.
  - When s1_valid and cnt == 2^WIN_LOG2-1 (last sample of window):
    - P = max(pk_k, a_k), so the current sample is included.
    - Vt_k <= (3*Vt_k + P) >> 2, computed in 18 bits; the result always fits in 16 bits.
    - pk_k <= 0 (the next window starts clean).
    - thr_update=1, asserted the same cycle as that sample's mp_valid.
- Window FSM, two states:
  - WARMUP: thr_ready=0.
  - RUN: thr_ready=1.
  - WARMUP -> RUN on the first thr_update.
  - RUN persists until rst.
- Gaps in in_valid: no state change, no pulses; outputs hold.
- Back-to-back in_valid: supported at full rate, one sample per cycle.
- Reset mid-window or mid-pipeline: all in-flight samples are discarded; values return to reset state on the next edge.

Decomposition:
- Shared package (qrs_pkg), holding:
  - COEF_W=16, MP_W=32, NSCALE=4.
  - sat_abs function.
  - Window-state enum {WARMUP, RUN}.
- One sub-module, abs_peak_tracker, instantiated 4×:
  - Inputs: a_k, s1_valid, window-end strobe.
  - Output: its Vt_k register with the IIR update.
- Top level owns:
  - Stage-1 registers.
  - MPavg history and running sum.
  - cnt and the FSM.

Test Plan:
- Reset check: d1..d4=100 held, rst high 3 cycles with in_valid=1 -> no mp_valid; MPavg=0, Vt1..4=64, thr_ready=0.
- MPavg ramp: d1..d4=100 constant, 10 consecutive valids -> first mp_valid 2 cycles after first in_valid; MPavg=50,100,...,400; stays at 400 from the 8th output on.
- Saturation: d1=-32768, d2=-1, d3=d4=0, single sample after reset -> stage-1 a1=32767, a2=1; S=32768; MPavg=4096.
- Window update (WIN_LOG2=2): d1 magnitudes 0,0,1000,0, others 0 -> on the 4th sample's mp_valid cycle:
  - thr_update=1.
  - Vt1=298 ((192+1000)>>2).
  - Vt2..4=48.
  - thr_ready rises.
  - A second identical window gives Vt1=473.
- Valid gaps: same stimulus as the window-update test with 3 idle cycles between samples -> identical MPavg and Vt values, pulses only on valid-derived cycles.
- Mid-window reset: 2 samples into a window, assert rst 1 cycle -> counter restarts; the next thr_update occurs only after 4 further samples; Vt values return to 64.
